regfile_sb: RTL and testbench

//  Parametrised integer register file for the RISC-V core, with a per-register pending-write scoreboard.

---
 rtl/rf_pkg.sv | 9 +
 rtl/regfile_scoreboard.sv | 67 ++++++
 rtl/regfile_sb.sv | 76 +++++++
 tb/tb_regfile_sb.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and types for the integer register file with scoreboard
package rf_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_idx_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write busy vector, WAW issue stall and pending count
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          IssueEn,
  input  logic [AW-1:0] IssueSel,
  input  logic          Wen,
  input  logic [AW-1:0] RDSel,
  input  logic [AW-1:0] RS1Sel,
  input  logic [AW-1:0] RS2Sel,
  output logic          RS1Busy,
  output logic          RS2Busy,
  output logic          IssueStall,
  output logic [AW:0]   PendCnt
);

  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      pend_q, pend_d;
  logic             wr_hit, iss_nz, retire_same, iss_ok, dec;

  assign wr_hit      = Wen && (RDSel != '0);
  assign iss_nz      = IssueEn && (IssueSel != '0);
  // A writeback to the same register retires the old owner, so a new issue may proceed.
  assign retire_same = wr_hit && (RDSel == IssueSel);
  assign IssueStall  = iss_nz && busy_q[IssueSel] && !retire_same;
  assign iss_ok      = iss_nz && !IssueStall;
  assign dec         = wr_hit && busy_q[RDSel];

  assign RS1Busy = busy_q[RS1Sel];
  assign RS2Busy = busy_q[RS2Sel];
  assign PendCnt = pend_q;

  // Issue is applied after the clear so the new owner wins on a same-register collision.
  always_comb begin
    busy_d = busy_q;
    if (wr_hit) busy_d[RDSel] = 1'b0;
    if (iss_ok) busy_d[IssueSel] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    pend_d = pend_q;
    case ({iss_ok, dec})
      2'b10:   pend_d = pend_q + CNT_ONE;
      2'b01:   pend_d = pend_q - CNT_ONE;
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with pending-write scoreboard; RF_BYPASS_EN enables write-to-read bypass
module regfile_sb
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [AW-1:0]   RS1Sel,
  input  logic [AW-1:0]   RS2Sel,
  output logic [XLEN-1:0] RS1Dat,
  output logic [XLEN-1:0] RS2Dat,
  output logic            RS1Busy,
  output logic            RS2Busy,
  input  logic            IssueEn,
  input  logic [AW-1:0]   IssueSel,
  output logic            IssueStall,
  input  logic            Wen,
  input  logic [AW-1:0]   RDSel,
  input  logic [XLEN-1:0] RDDat,
  output logic [AW:0]     PendCnt
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;
  logic [XLEN-1:0] rs1_raw, rs2_raw;
  logic            sb_rs1_busy, sb_rs2_busy;
  logic            rs1_hit, rs2_hit;

  assign wr_en = Wen && (RDSel != '0);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[RDSel] <= RDDat;
    end
  end

  regfile_scoreboard #(
    .NREGS(NREGS)
  ) u_scoreboard (
    .Clk       (Clk),
    .Rst       (Rst),
    .IssueEn   (IssueEn),
    .IssueSel  (IssueSel),
    .Wen       (Wen),
    .RDSel     (RDSel),
    .RS1Sel    (RS1Sel),
    .RS2Sel    (RS2Sel),
    .RS1Busy   (sb_rs1_busy),
    .RS2Busy   (sb_rs2_busy),
    .IssueStall(IssueStall),
    .PendCnt   (PendCnt)
  );

  assign rs1_raw = (RS1Sel == '0) ? '0 : regs_q[RS1Sel];
  assign rs2_raw = (RS2Sel == '0) ? '0 : regs_q[RS2Sel];

`ifdef RF_BYPASS_EN
  assign rs1_hit = wr_en && (RS1Sel == RDSel);
  assign rs2_hit = wr_en && (RS2Sel == RDSel);
`else
  assign rs1_hit = 1'b0;
  assign rs2_hit = 1'b0;
`endif

  // A bypassed read sees the value being retired, so it is no longer pending.
  assign RS1Dat  = rs1_hit ? RDDat : rs1_raw;
  assign RS2Dat  = rs2_hit ? RDDat : rs2_raw;
  assign RS1Busy = rs1_hit ? 1'b0 : sb_rs1_busy;
  assign RS2Busy = rs2_hit ? 1'b0 : sb_rs2_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb against a behavioural array model
module tb_regfile_sb;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  RS1Sel, RS2Sel, IssueSel, RDSel;
  logic [31:0] RS1Dat, RS2Dat, RDDat;
  logic        RS1Busy, RS2Busy, IssueEn, IssueStall, Wen;
  logic [5:0]  PendCnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_reg  [32];
  bit          m_busy [32];

  regfile_sb dut (
    .Clk(Clk), .Rst(Rst),
    .RS1Sel(RS1Sel), .RS2Sel(RS2Sel), .RS1Dat(RS1Dat), .RS2Dat(RS2Dat),
    .RS1Busy(RS1Busy), .RS2Busy(RS2Busy),
    .IssueEn(IssueEn), .IssueSel(IssueSel), .IssueStall(IssueStall),
    .Wen(Wen), .RDSel(RDSel), .RDDat(RDDat), .PendCnt(PendCnt)
  );

  always #5 Clk = ~Clk;

  function automatic bit bypass_hit(input logic [4:0] sel);
`ifdef RF_BYPASS_EN
    return Wen && RDSel != 0 && RDSel == sel;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_dat(input logic [4:0] sel);
    if (sel == 0) return 32'h0;
    if (bypass_hit(sel)) return RDDat;
    return m_reg[sel];
  endfunction

  function automatic logic exp_busy(input logic [4:0] sel);
    if (bypass_hit(sel)) return 1'b0;
    return m_busy[sel];
  endfunction

  function automatic logic exp_stall();
    return IssueEn && IssueSel != 0 && m_busy[IssueSel] && !(Wen && RDSel != 0 && RDSel == IssueSel);
  endfunction

  function automatic logic [5:0] exp_pend();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return 6'(n);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    IssueEn = 0; IssueSel = 0; Wen = 0; RDSel = 0; RDDat = 0;
  endtask

  // Advance one clock edge, applying the architectural rules to the model.
  task automatic cycle();
    bit stall;
    @(posedge Clk);
    stall = exp_stall();
    if (Wen && RDSel != 0) begin
      m_reg[RDSel]  = RDDat;
      m_busy[RDSel] = 1'b0;
    end
    if (IssueEn && IssueSel != 0 && !stall) m_busy[IssueSel] = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst = 0; idle_inputs(); RS1Sel = 0; RS2Sel = 0;
    model_clear();
    repeat (2) @(negedge Clk);
    Rst = 1;
    @(negedge Clk);
    for (int s = 0; s < 32; s += 9) begin
      RS1Sel = 5'(s); RS2Sel = 5'(31 - s); #1;
      checks++;
      if (RS1Dat !== 32'h0 || RS2Dat !== 32'h0 || RS1Busy !== 1'b0 || RS2Busy !== 1'b0 ||
          PendCnt !== 6'd0 || IssueStall !== 1'b0) begin
        errors++;
        $display("FAIL reset_state sel=%0d: rs1=%h rs2=%h b1=%b b2=%b pend=%0d stall=%b, required all zero",
                 s, RS1Dat, RS2Dat, RS1Busy, RS2Busy, PendCnt, IssueStall);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_reset_mid_run();
    Wen = 1; RDSel = 5; RDDat = 32'hCAFE_0005; cycle();
    Wen = 0; IssueEn = 1; IssueSel = 12; cycle();
    idle_inputs(); RS1Sel = 5; RS2Sel = 12; #1;
    checks++;
    if (RS1Dat !== 32'hCAFE_0005 || RS2Busy !== 1'b1 || PendCnt !== 6'd1) begin
      errors++;
      $display("FAIL preload: rs1=%h b2=%b pend=%0d, required cafe0005 1 1", RS1Dat, RS2Busy, PendCnt);
    end
    #2 Rst = 0; #1;
    checks++;
    if (RS1Dat !== 32'h0 || RS2Busy !== 1'b0 || PendCnt !== 6'd0) begin
      errors++;
      $display("FAIL async_reset: rs1=%h b2=%b pend=%0d, required 0 0 0", RS1Dat, RS2Busy, PendCnt);
    end
    model_clear();
    @(negedge Clk); Rst = 1; @(negedge Clk); #1;
    checks++;
    if (RS1Dat !== 32'h0 || RS2Busy !== 1'b0 || PendCnt !== 6'd0) begin
      errors++;
      $display("FAIL reset_release: rs1=%h b2=%b pend=%0d, required 0 0 0", RS1Dat, RS2Busy, PendCnt);
    end
    @(negedge Clk);
  endtask

  task automatic test_x0();
    Wen = 1; RDSel = 0; RDDat = 32'hDEADBEEF; IssueEn = 1; IssueSel = 0; RS1Sel = 0; #1;
    checks++;
    if (IssueStall !== 1'b0 || RS1Dat !== 32'h0) begin
      errors++;
      $display("FAIL x0_same_cycle: stall=%b rs1=%h, required 0 0", IssueStall, RS1Dat);
    end
    cycle();
    idle_inputs(); #1;
    checks++;
    if (RS1Dat !== 32'h0 || RS1Busy !== 1'b0 || PendCnt !== 6'd0) begin
      errors++;
      $display("FAIL x0_after: rs1=%h busy=%b pend=%0d, required 0 0 0", RS1Dat, RS1Busy, PendCnt);
    end
  endtask

  task automatic test_issue_write();
    IssueEn = 1; IssueSel = 7; cycle();
    IssueEn = 0; RS1Sel = 7; #1;
    checks++;
    if (RS1Busy !== 1'b1 || PendCnt !== 6'd1) begin
      errors++;
      $display("FAIL issue_x7: busy=%b pend=%0d, required 1 1", RS1Busy, PendCnt);
    end
    IssueEn = 1; IssueSel = 7; #1;
    checks++;
    if (IssueStall !== 1'b1) begin
      errors++;
      $display("FAIL waw_stall: stall=%b, required 1", IssueStall);
    end
    cycle();
    IssueEn = 0; #1;
    checks++;
    if (PendCnt !== 6'd1) begin
      errors++;
      $display("FAIL stalled_issue_ignored: pend=%0d, required 1", PendCnt);
    end
    Wen = 1; RDSel = 7; RDDat = 32'h1234; cycle();
    Wen = 0; #1;
    checks++;
    if (RS1Dat !== 32'h1234 || RS1Busy !== 1'b0 || PendCnt !== 6'd0) begin
      errors++;
      $display("FAIL writeback_x7: dat=%h busy=%b pend=%0d, required 1234 0 0", RS1Dat, RS1Busy, PendCnt);
    end
  endtask

  task automatic test_same_edge();
    IssueEn = 1; IssueSel = 9; cycle();
    Wen = 1; RDSel = 9; RDDat = 32'hA5; #1;
    checks++;
    if (IssueStall !== 1'b0) begin
      errors++;
      $display("FAIL same_edge_stall: stall=%b, required 0", IssueStall);
    end
    cycle();
    idle_inputs(); RS1Sel = 9; #1;
    checks++;
    if (RS1Dat !== 32'hA5 || RS1Busy !== 1'b1 || PendCnt !== 6'd1) begin
      errors++;
      $display("FAIL same_edge_result: dat=%h busy=%b pend=%0d, required a5 1 1", RS1Dat, RS1Busy, PendCnt);
    end
    Wen = 1; RDSel = 9; RDDat = 32'hA6; cycle();
    Wen = 0;
  endtask

  task automatic test_bypass();
    Wen = 1; RDSel = 3; RDDat = 32'h11; cycle();
    Wen = 0; IssueEn = 1; IssueSel = 3; cycle();
    IssueEn = 0; Wen = 1; RDSel = 3; RDDat = 32'h55; RS2Sel = 3; RS1Sel = 4; #1;
    checks++;
`ifdef RF_BYPASS_EN
    if (RS2Dat !== 32'h55 || RS2Busy !== 1'b0) begin
      errors++;
      $display("FAIL bypass_same_cycle: dat=%h busy=%b, required 55 0", RS2Dat, RS2Busy);
    end
`else
    if (RS2Dat !== 32'h11 || RS2Busy !== 1'b1) begin
      errors++;
      $display("FAIL no_bypass_same_cycle: dat=%h busy=%b, required 11 1", RS2Dat, RS2Busy);
    end
`endif
    checks++;
    if (RS1Dat !== m_reg[4]) begin
      errors++;
      $display("FAIL bypass_other_port: dat=%h, required %h", RS1Dat, m_reg[4]);
    end
    cycle();
    Wen = 0; #1;
    checks++;
    if (RS2Dat !== 32'h55 || RS2Busy !== 1'b0) begin
      errors++;
      $display("FAIL write_next_cycle: dat=%h busy=%b, required 55 0", RS2Dat, RS2Busy);
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    for (int i = 1; i < 32; i++) begin
      IssueEn = 1; IssueSel = 5'(i); #1;
      checks++;
      if (IssueStall !== 1'b0) begin
        errors++;
        $display("FAIL b2b_issue x%0d: stall=%b, required 0", i, IssueStall);
      end
      cycle();
    end
    IssueEn = 0; #1;
    checks++;
    if (PendCnt !== 6'd31) begin
      errors++;
      $display("FAIL b2b_full: pend=%0d, required 31", PendCnt);
    end
    for (int i = 31; i >= 1; i--) begin
      Wen = 1; RDSel = 5'(i); RDDat = $urandom; cycle();
      Wen = 0; #1;
      checks++;
      if (PendCnt !== 6'(i - 1)) begin
        errors++;
        $display("FAIL b2b_drain x%0d: pend=%0d, required %0d", i, PendCnt, i - 1);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      IssueEn  = ($urandom_range(0, 2) != 0);
      IssueSel = 5'($urandom_range(0, 31));
      Wen      = ($urandom_range(0, 1) != 0);
      RDSel    = ($urandom_range(0, 3) == 0) ? IssueSel : 5'($urandom_range(0, 31));
      RDDat    = $urandom;
      RS1Sel   = ($urandom_range(0, 3) == 0) ? RDSel : 5'($urandom_range(0, 31));
      RS2Sel   = 5'($urandom_range(0, 31));
      #1;
      checks++;
      if (RS1Dat !== exp_dat(RS1Sel) || RS2Dat !== exp_dat(RS2Sel) ||
          RS1Busy !== exp_busy(RS1Sel) || RS2Busy !== exp_busy(RS2Sel) ||
          IssueStall !== exp_stall() || PendCnt !== exp_pend()) begin
        errors++;
        $display("FAIL random[%0d]: got d1=%h d2=%h b1=%b b2=%b st=%b pc=%0d, required d1=%h d2=%h b1=%b b2=%b st=%b pc=%0d",
                 n, RS1Dat, RS2Dat, RS1Busy, RS2Busy, IssueStall, PendCnt,
                 exp_dat(RS1Sel), exp_dat(RS2Sel), exp_busy(RS1Sel), exp_busy(RS2Sel), exp_stall(), exp_pend());
      end
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_x0();
    test_issue_write();
    test_same_edge();
    test_bypass();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
